// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller and its decoder.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t BLANK = 2'd1;
  localparam state_t DRIVE = 2'd2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_decoder.sv
// 4-bit hex to active-low seven-segment decoder, bit 6 = segment a down to bit 0 = segment g.
module SevenSegment
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    case (hex)
      4'h0: seg_n = 7'h01;
      4'h1: seg_n = 7'h4F;
      4'h2: seg_n = 7'h12;
      4'h3: seg_n = 7'h06;
      4'h4: seg_n = 7'h4C;
      4'h5: seg_n = 7'h24;
      4'h6: seg_n = 7'h20;
      4'h7: seg_n = 7'h0F;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h04;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h60;
      4'hC: seg_n = 7'h31;
      4'hD: seg_n = 7'h42;
      4'hE: seg_n = 7'h30;
      4'hF: seg_n = 7'h38;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode display scanner with anti-ghost blanking,
// leading-zero suppression and a double-buffered valid/ready frame load.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int PW = clog2(REFRESH_DIV);
  localparam int IW = clog2(NUM_DIGITS);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] SLOT_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                  state;
  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] pend;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    disp_lz;
  logic                    pend_lz;
  logic                    pend_full;
  logic                    accept;
  logic                    frame_end;
  logic                    lz_blank;
  logic [3:0]              cur_nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   an_next;

  assign load_ready = ~pend_full;
  assign accept     = load_valid & ~pend_full;
  assign frame_end  = enable && (state == DRIVE) && (prescaler == SLOT_LAST) && (idx == IDX_LAST);
  assign cur_nibble = disp[{idx, 2'b00} +: 4];

  SevenSegment decoder (
    .hex   (cur_nibble),
    .seg_n (dec_seg)
  );

  // A digit is a leading zero when it and every more-significant digit are zero;
  // digit 0 always shows so a zero value still reads "0".
  always_comb begin
    lz_blank = disp_lz && (idx != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && disp[4*i +: 4] != 4'h0) lz_blank = 1'b0;
    end
  end

  always_comb begin
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == int'(idx)) an_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      state     <= IDLE;
      idx       <= '0;
      prescaler <= '0;
    end else begin
      case (state)
        IDLE: begin
          state     <= BLANK;
          prescaler <= '0;
          idx       <= '0;
        end
        BLANK: begin
          prescaler <= prescaler + 1'b1;
          if (prescaler == BLANK_LAST) state <= DRIVE;
        end
        DRIVE: begin
          if (prescaler == SLOT_LAST) begin
            prescaler <= '0;
            idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            state     <= BLANK;
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display registers only change at frame end so no digit shows a torn frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_dp   <= '0;
      pend_lz   <= 1'b0;
      pend_full <= 1'b0;
      disp      <= '0;
      disp_dp   <= '0;
      disp_lz   <= 1'b0;
    end else if (accept) begin
      pend      <= data_in;
      pend_dp   <= dp_in;
      pend_lz   <= blank_lz;
      pend_full <= 1'b1;
    end else if (frame_end && pend_full) begin
      disp      <= pend;
      disp_dp   <= pend_dp;
      disp_lz   <= pend_lz;
      pend_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (enable && state == DRIVE) begin
        an_n  <= an_next;
        seg_n <= lz_blank ? SEG_OFF : dec_seg;
        dp_n  <= ~disp_dp[idx];
      end else begin
        an_n  <= '1;
        seg_n <= SEG_OFF;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-position reference model checked every
// cycle, a table of display frames, and hand-written multi-cycle corner cases.
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int B     = 2;
  localparam int FRAME = N * R;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         load_valid;
  logic         load_ready;
  logic [4*N-1:0] data_in;
  logic [N-1:0] dp_in;
  logic         blank_lz;
  logic [6:0]   seg_n;
  logic         dp_n;
  logic [N-1:0] an_n;
  logic         frame_tick;

  int errors = 0;
  int checks = 0;
  int dut_accepts = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: sc is the position inside a frame (-1 while idle), digit = sc / R,
  // and the digit is lit once sc % R has passed the blank interval.
  logic [6:0]   seg_tab [16];
  int           sc;
  bit           m_pend_full;
  logic [15:0]  m_pend, m_disp;
  logic [3:0]   m_pend_dp, m_disp_dp;
  logic         m_pend_lz, m_disp_lz;
  logic [6:0]   e_seg;
  logic         e_dp_n, e_tick, e_ready;
  logic [3:0]   e_an;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] segs;
    logic [3:0]      dpn;
  } vec_t;

  vec_t vecs [7];

  task automatic model_step();
    int  d, ph;
    bit  fe, lz;
    if (!rst_n) begin
      sc = -1;
      m_pend_full = 0;
      m_pend = '0; m_pend_dp = '0; m_pend_lz = 0;
      m_disp = '0; m_disp_dp = '0; m_disp_lz = 0;
      e_an = '1; e_seg = 7'h7F; e_dp_n = 1; e_tick = 0;
    end else begin
      fe = enable && (sc == FRAME - 1);
      if (enable && sc >= 0 && (sc % R) >= B) begin
        d  = sc / R;
        lz = m_disp_lz && (d != 0);
        for (int k = d; k < N; k++) if (m_disp[4*k +: 4] != 4'h0) lz = 0;
        e_an    = '1;
        e_an[d] = 1'b0;
        e_seg   = lz ? 7'h7F : seg_tab[m_disp[4*d +: 4]];
        e_dp_n  = !m_disp_dp[d];
      end else begin
        e_an = '1; e_seg = 7'h7F; e_dp_n = 1;
      end
      e_tick = fe;
      if (load_valid && !m_pend_full) begin
        m_pend = data_in; m_pend_dp = dp_in; m_pend_lz = blank_lz;
        m_pend_full = 1;
      end else if (fe && m_pend_full) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_disp_lz = m_pend_lz;
        m_pend_full = 0;
      end
      ph = sc;
      sc = !enable ? -1 : (ph < 0 ? 0 : (ph + 1) % FRAME);
    end
    e_ready = !m_pend_full;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic step_cycle();
    if (load_ready === 1'b1 && load_valid) dut_accepts++;
    @(posedge clk);
    model_step();
    #1;
    checks++;
    if ({an_n, seg_n, dp_n, frame_tick, load_ready} !== {e_an, e_seg, e_dp_n, e_tick, e_ready}) begin
      errors++;
      $display("[TB] FAIL cycle_model t=%0t an_n=%b seg_n=%h dp_n=%b tick=%b ready=%b expected an_n=%b seg_n=%h dp_n=%b tick=%b ready=%b",
               $time, an_n, seg_n, dp_n, frame_tick, load_ready, e_an, e_seg, e_dp_n, e_tick, e_ready);
    end
  endtask

  task automatic wait_frame_tick(input string name);
    int n = 0;
    do begin
      step_cycle();
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    check_output(name, frame_tick, 1'b1);
  endtask

  task automatic load_frame(input logic [15:0] data, input logic [3:0] dp, input logic lz);
    int n = 0;
    data_in = data; dp_in = dp; blank_lz = lz; load_valid = 1;
    while (load_ready !== 1'b1 && n < 200) begin
      step_cycle();
      n++;
    end
    check_output("load_ready_wait", load_ready, 1'b1);
    step_cycle();
    load_valid = 0;
  endtask

  task automatic ticks_to_lit(output int n);
    n = 0;
    do begin
      step_cycle();
      n++;
    end while (an_n === 4'hF && n < 100);
  endtask

  task automatic capture_frame(output logic [3:0][6:0] segs, output logic [3:0] dpn);
    logic [3:0] pat;
    segs = 'x;
    dpn  = 'x;
    for (int c = 0; c < FRAME; c++) begin
      step_cycle();
      for (int d = 0; d < N; d++) begin
        pat = 4'hF;
        pat[d] = 1'b0;
        if (an_n === pat) begin
          segs[d] = seg_n;
          dpn[d]  = dp_n;
        end
      end
    end
  endtask

  initial begin
    logic [3:0][6:0] segs;
    logic [3:0]      dpn;
    int              n, lit;

    seg_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    vecs[0] = '{data: 16'h12AF, dp: 4'b0010, lz: 1'b0, segs: {7'h4F, 7'h12, 7'h08, 7'h38}, dpn: 4'b1101};
    vecs[1] = '{data: 16'h0007, dp: 4'b0000, lz: 1'b1, segs: {7'h7F, 7'h7F, 7'h7F, 7'h0F}, dpn: 4'b1111};
    vecs[2] = '{data: 16'h0000, dp: 4'b0000, lz: 1'b1, segs: {7'h7F, 7'h7F, 7'h7F, 7'h01}, dpn: 4'b1111};
    vecs[3] = '{data: 16'h0500, dp: 4'b1000, lz: 1'b1, segs: {7'h7F, 7'h24, 7'h01, 7'h01}, dpn: 4'b0111};
    vecs[4] = '{data: 16'hC3E9, dp: 4'b0101, lz: 1'b1, segs: {7'h31, 7'h06, 7'h30, 7'h04}, dpn: 4'b1010};
    vecs[5] = '{data: 16'h0B6D, dp: 4'b0000, lz: 1'b0, segs: {7'h01, 7'h60, 7'h20, 7'h42}, dpn: 4'b1111};
    vecs[6] = '{data: 16'h0080, dp: 4'b0100, lz: 1'b1, segs: {7'h7F, 7'h7F, 7'h00, 7'h01}, dpn: 4'b1011};

    rst_n = 0; enable = 0; load_valid = 0; data_in = '0; dp_in = '0; blank_lz = 0;
    step_cycle();
    step_cycle();
    check_output("reset_an_n", an_n, 4'hF);
    check_output("reset_seg_n", seg_n, 7'h7F);
    check_output("reset_dp_n", dp_n, 1'b1);
    check_output("reset_frame_tick", frame_tick, 1'b0);
    check_output("reset_load_ready", load_ready, 1'b1);

    // Scan start-up latency, slot timing and frame period with an all-zero display.
    rst_n = 1; enable = 1;
    ticks_to_lit(n);
    check_output("startup_latency", n, 4);
    check_output("startup_digit", an_n, 4'b1110);
    check_output("startup_seg", seg_n, 7'h01);
    wait_frame_tick("first_frame_tick");
    n = 0; lit = 0;
    do begin
      step_cycle();
      n++;
      if (an_n !== 4'hF) lit++;
    end while (frame_tick !== 1'b1 && n < 100);
    check_output("frame_period", n, FRAME);
    check_output("lit_cycles_per_frame", lit, N * (R - B));

    foreach (vecs[i]) begin
      load_frame(vecs[i].data, vecs[i].dp, vecs[i].lz);
      check_output($sformatf("vec%0d_ready_low", i), load_ready, 1'b0);
      wait_frame_tick($sformatf("vec%0d_commit", i));
      capture_frame(segs, dpn);
      for (int d = 0; d < N; d++)
        check_output($sformatf("vec%0d_seg%0d", i, d), segs[d], vecs[i].segs[d]);
      check_output($sformatf("vec%0d_dp", i), dpn, vecs[i].dpn);
    end

    // load_valid held high across three frames: one accept per frame.
    wait_frame_tick("hold_align");
    load_valid = 1;
    dut_accepts = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      data_in = 16'($urandom); dp_in = 4'($urandom); blank_lz = 1'($urandom);
      step_cycle();
    end
    load_valid = 0;
    check_output("hold_accepts", dut_accepts, 3);

    // Enable dropped mid-DRIVE of digit 2 with a frame pending.
    load_frame(16'h4321, 4'b0000, 1'b0);
    n = 0;
    while (sc != 2 * R + 4 && n < 200) begin
      step_cycle();
      n++;
    end
    check_output("reach_digit2", sc, 2 * R + 4);
    enable = 0;
    step_cycle();
    check_output("disable_an_n", an_n, 4'hF);
    check_output("disable_seg_n", seg_n, 7'h7F);
    repeat (20) step_cycle();
    check_output("disable_ready_held", load_ready, 1'b0);
    enable = 1;
    ticks_to_lit(n);
    check_output("restart_latency", n, 4);
    check_output("restart_digit", an_n, 4'b1110);
    check_output("restart_old_data", seg_n, seg_tab[m_disp[3:0]]);
    wait_frame_tick("restart_commit");
    capture_frame(segs, dpn);
    check_output("restart_frame", segs, {7'h4C, 7'h06, 7'h12, 7'h4F});

    // Reset while a frame is pending discards it and clears the display.
    load_frame(16'h89AB, 4'b1111, 1'b0);
    rst_n = 0;
    step_cycle();
    rst_n = 1;
    check_output("midreset_ready", load_ready, 1'b1);
    check_output("midreset_an_n", an_n, 4'hF);
    check_output("midreset_seg_n", seg_n, 7'h7F);
    capture_frame(segs, dpn);
    check_output("midreset_frame", segs, {7'h01, 7'h01, 7'h01, 7'h01});
    check_output("midreset_dp", dpn, 4'b1111);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      enable     = ($urandom_range(0, 15) != 0);
      load_valid = 1'($urandom);
      data_in    = 16'($urandom);
      dp_in      = 4'($urandom);
      blank_lz   = 1'($urandom);
      if ($urandom_range(0, 3) == 0) data_in = {12'h000, 4'($urandom)};
      step_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
